// File: rtl/led_activity_pkg.sv
// Shared constants and types for the board LED activity/link indicator block.
package led_activity_pkg;

   localparam logic LED_ON  = 1'b1;
   localparam logic LED_OFF = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ON   = 2'b01,
      ST_GAP  = 2'b10
   } act_st_e;

   localparam int unsigned CLK_HZ       = 32'd60000000;
   localparam int unsigned DEF_ON_CYC   = CLK_HZ / 32'd20;
   localparam int unsigned DEF_OFF_CYC  = CLK_HZ / 32'd20;
   localparam int unsigned DEF_LINK_DEB = CLK_HZ / 32'd100;

   // Width able to hold max(a,b)-1, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 32'd1) ? unsigned'($clog2(m)) : 32'd1;
   endfunction

endpackage

// File: rtl/led_act_stretch.sv
// Stretches single-cycle activity strobes into a visible blink with a
// minimum on-time and forced off-gap; strobes seen while busy are remembered.
module led_act_stretch
   import led_activity_pkg::*;
#(
   parameter int unsigned P_ON_CYC  = DEF_ON_CYC,
   parameter int unsigned P_OFF_CYC = DEF_OFF_CYC
) (
   input  logic i_clk,
   input  logic i_res_n,
   input  logic i_act,
   output logic o_led
);

   localparam int unsigned     CW       = cnt_width(P_ON_CYC, P_OFF_CYC);
   localparam logic [CW-1:0]   ON_LOAD  = CW'(P_ON_CYC - 32'd1);
   localparam logic [CW-1:0]   OFF_LOAD = CW'(P_OFF_CYC - 32'd1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};

   act_st_e        st_q, st_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           pend_q, pend_d;
   logic           led_q, led_d;

   // Next-state logic for the blink FSM, its timer and the pending flag.
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      case (st_q)
         ST_IDLE: begin
            if (i_act) begin
               st_d  = ST_ON;
               cnt_d = ON_LOAD;
            end else begin
               st_d  = ST_IDLE;
            end
         end
         ST_ON: begin
            pend_d = pend_q | i_act;
            if (cnt_q == CNT_ZERO) begin
               st_d  = ST_GAP;
               cnt_d = OFF_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_ZERO) begin
               // A strobe on the very last gap cycle still earns a new blink.
               pend_d = 1'b0;
               if (pend_q | i_act) begin
                  st_d  = ST_ON;
                  cnt_d = ON_LOAD;
               end else begin
                  st_d  = ST_IDLE;
               end
            end else begin
               pend_d = pend_q | i_act;
               cnt_d  = cnt_q - CNT_ONE;
            end
         end
         default: begin
            st_d   = ST_IDLE;
            cnt_d  = CNT_ZERO;
            pend_d = 1'b0;
         end
      endcase
      led_d = (st_d == ST_ON) ? LED_ON : LED_OFF;
   end

   // State, timer, pending flag and LED output registers.
   always_ff @(posedge i_clk) begin
      if (!i_res_n) begin
         st_q   <= ST_IDLE;
         cnt_q  <= CNT_ZERO;
         pend_q <= 1'b0;
         led_q  <= LED_OFF;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         led_q  <= led_d;
      end
   end

   assign o_led = led_q;

endmodule

// File: rtl/led_activity.sv
// RX/TX LED request generator: stretched activity blink on bit 1 and a
// synchronised, debounced link/health indicator on bit 0 of each channel.
module led_activity
   import led_activity_pkg::*;
#(
   parameter int unsigned P_ON_CYC   = DEF_ON_CYC,
   parameter int unsigned P_OFF_CYC  = DEF_OFF_CYC,
   parameter int unsigned P_LINK_DEB = DEF_LINK_DEB
) (
   input  logic       i_clk,
   input  logic       i_res_n,
   input  logic       i_rx_act,
   input  logic       i_tx_act,
   input  logic       i_rx_los,
   input  logic       i_tx_fault,
   output logic [1:0] o_rx_led,
   output logic [1:0] o_tx_led
);

   localparam int unsigned   DW       = (P_LINK_DEB > 32'd1) ? unsigned'($clog2(P_LINK_DEB)) : 32'd1;
   localparam logic [DW-1:0] DEB_LAST = DW'(P_LINK_DEB - 32'd1);
   localparam logic [DW-1:0] DEB_ONE  = DW'(32'd1);
   localparam logic [DW-1:0] DEB_ZERO = {DW{1'b0}};

   // Index 0 is the RX channel (LOS), index 1 the TX channel (fault).
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         lnk_q, lnk_d;
   logic [1:0][DW-1:0] deb_q, deb_d;
   logic               rx_act_led, tx_act_led;

   led_act_stretch #(
      .P_ON_CYC  (P_ON_CYC),
      .P_OFF_CYC (P_OFF_CYC)
   ) u_rx_act (
      .i_clk   (i_clk),
      .i_res_n (i_res_n),
      .i_act   (i_rx_act),
      .o_led   (rx_act_led)
   );

   led_act_stretch #(
      .P_ON_CYC  (P_ON_CYC),
      .P_OFF_CYC (P_OFF_CYC)
   ) u_tx_act (
      .i_clk   (i_clk),
      .i_res_n (i_res_n),
      .i_act   (i_tx_act),
      .o_led   (tx_act_led)
   );

   // Debounce: the LED only follows a status that has disagreed with it for
   // P_LINK_DEB consecutive cycles; LED polarity is the inverse of the pin.
   always_comb begin
      lnk_d = lnk_q;
      deb_d = deb_q;
      for (int ch = 0; ch < 2; ch++) begin
         if (~sync2_q[ch] != lnk_q[ch]) begin
            if (deb_q[ch] == DEB_LAST) begin
               lnk_d[ch] = ~lnk_q[ch];
               deb_d[ch] = DEB_ZERO;
            end else begin
               deb_d[ch] = deb_q[ch] + DEB_ONE;
            end
         end else begin
            deb_d[ch] = DEB_ZERO;
         end
      end
   end

   // Synchronisers reset to the "bad" level so link LEDs start dark.
   always_ff @(posedge i_clk) begin
      if (!i_res_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         lnk_q   <= {LED_OFF, LED_OFF};
         deb_q   <= {(2*DW){1'b0}};
      end else begin
         sync1_q <= {i_tx_fault, i_rx_los};
         sync2_q <= sync1_q;
         lnk_q   <= lnk_d;
         deb_q   <= deb_d;
      end
   end

   assign o_rx_led = {rx_act_led, lnk_q[0]};
   assign o_tx_led = {tx_act_led, lnk_q[1]};

endmodule
